// File: rtl/pim_weight_loader_pkg.sv
// Shared sizes, FSM states and slice selects for the PIM weight loader.
// Imported by the loader top and its slice packer.
package pim_weight_loader_pkg;

  localparam int KSIZE  = 25;
  localparam int WBITS  = 6;
  localparam int SLICE  = 3;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int ROW_W  = KSIZE * SLICE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KSIZE - 1);

  localparam logic SLICE_HI = 1'b0;
  localparam logic SLICE_LO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WR_HI,
    ST_WR_LO
  } state_e;

endpackage

// File: rtl/pim_weight_loader_packer.sv
// Splits 25 six-bit weights into packed high and low 3-bit slice rows.
// Ports: wts (weight slots) in; hi_row, lo_row out, weight 0 in the MSBs.
module pim_slice_packer
  import pim_weight_loader_pkg::*;
(
  input  logic [WBITS-1:0] wts [KSIZE],
  output logic [ROW_W-1:0] hi_row,
  output logic [ROW_W-1:0] lo_row
);

  always_comb begin
    hi_row = '0;
    lo_row = '0;
    for (int k = 0; k < KSIZE; k++) begin
      hi_row[ROW_W-1-SLICE*k -: SLICE] = wts[k][WBITS-1:SLICE];
      lo_row[ROW_W-1-SLICE*k -: SLICE] = wts[k][SLICE-1:0];
    end
  end

endmodule

// File: rtl/pim_weight_loader.sv
// Collects 25-weight kernels and writes hi/lo slice rows into the crossbar.
// Ports: cfg_* session setup, w_* weight stream, pim_wr_* write port, status.
module pim_weight_loader
  import pim_weight_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_kernels,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [WBITS-1:0]  w_data,
  input  logic              w_last,
  output logic              pim_wr_en,
  output logic              pim_wr_slice,
  output logic [ADDR_W-1:0] pim_wr_addr,
  output logic [ROW_W-1:0]  pim_wr_row,
  input  logic              pim_wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err_last
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WBITS-1:0]  wts_q [KSIZE];
  logic [WBITS-1:0]  wts_d [KSIZE];
  logic              w_ready_q, w_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              slice_q, slice_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROW_W-1:0]  hi_row, lo_row;
  logic              accept;

  // Packs the next-state slots so the 25th beat lands in the hi row
  // on the same edge it is accepted.
  pim_slice_packer u_packer (
    .wts    (wts_d),
    .hi_row (hi_row),
    .lo_row (lo_row)
  );

  assign accept = (state_q == ST_COLLECT) && w_valid && w_ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    wts_d     = wts_q;
    w_ready_d = w_ready_q;
    wr_en_d   = wr_en_q;
    slice_d   = slice_q;
    row_d     = row_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_num_kernels != '0) begin
            state_d   = ST_COLLECT;
            addr_d    = cfg_base_addr;
            rem_d     = cfg_num_kernels;
            idx_d     = '0;
            err_d     = 1'b0;
            w_ready_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          wts_d[idx_q] = w_data;
          if (w_last != (idx_q == LAST_IDX)) begin
            err_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            state_d   = ST_WR_HI;
            w_ready_d = 1'b0;
            wr_en_d   = 1'b1;
            slice_d   = SLICE_HI;
            row_d     = hi_row;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WR_HI: begin
        if (pim_wr_ack) begin
          state_d = ST_WR_LO;
          slice_d = SLICE_LO;
          row_d   = lo_row;
        end
      end
      ST_WR_LO: begin
        if (pim_wr_ack) begin
          rem_d   = rem_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          wr_en_d = 1'b0;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_COLLECT;
            w_ready_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      w_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      slice_q   <= SLICE_HI;
      row_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < KSIZE; k++) begin
        wts_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      w_ready_q <= w_ready_d;
      wr_en_q   <= wr_en_d;
      slice_q   <= slice_d;
      row_q     <= row_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      for (int k = 0; k < KSIZE; k++) begin
        wts_q[k] <= wts_d[k];
      end
    end
  end

  assign w_ready      = w_ready_q;
  assign pim_wr_en    = wr_en_q;
  assign pim_wr_slice = slice_q;
  assign pim_wr_addr  = addr_q;
  assign pim_wr_row   = row_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_last     = err_q;

endmodule

// File: tb/tb_pim_weight_loader.sv
// Randomized self-checking bench for pim_weight_loader.
// Expected rows come from a per-weight div/mod slice model.
module tb_pim_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [4:0]  cfg_base_addr;
  logic [5:0]  cfg_num_kernels;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  w_data;
  logic        w_last;
  logic        pim_wr_en;
  logic        pim_wr_slice;
  logic [4:0]  pim_wr_addr;
  logic [74:0] pim_wr_row;
  logic        pim_wr_ack;
  logic        busy;
  logic        done;
  logic        err_last;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wk [25];

  pim_weight_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_num_kernels (cfg_num_kernels),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .w_last          (w_last),
    .pim_wr_en       (pim_wr_en),
    .pim_wr_slice    (pim_wr_slice),
    .pim_wr_addr     (pim_wr_addr),
    .pim_wr_row      (pim_wr_row),
    .pim_wr_ack      (pim_wr_ack),
    .busy            (busy),
    .done            (done),
    .err_last        (err_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pim_wr_en && pim_wr_ack) wr_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] ref_row(input bit hi);
    logic [74:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 25; k++) begin
      v = hi ? wk[k] / 8 : wk[k] % 8;
      r = (r << 3) | 75'(v);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 25; k++) wk[k] = int'($urandom_range(0, 63));
  endtask

  task automatic start(input int b, input int n);
    cfg_start       = 1'b1;
    cfg_base_addr   = 5'(b);
    cfg_num_kernels = 6'(n);
    step();
    cfg_start = 1'b0;
    if (n > 0) begin
      chk("start_busy", busy, 1);
      chk("start_ready", w_ready, 1);
    end
  endtask

  task automatic send(input int lo, input int hi, input int bad);
    bit ok;
    for (int i = lo; i < hi; i++) begin
      repeat ($urandom_range(0, 2)) step();
      w_valid = 1'b1;
      w_data  = 6'(wk[i]);
      w_last  = (i == 24) != (i == bad);
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        ok = w_ready;
        step();
      end
      if (!ok) chk("beat_accept", 0, 1);
      w_valid = 1'b0;
      w_last  = 1'b0;
    end
  endtask

  task automatic check_write(input int addr, input int stall);
    logic [74:0] hr;
    logic [74:0] lr;
    hr = ref_row(1);
    lr = ref_row(0);
    for (int s = 0; s <= stall; s++) begin
      pim_wr_ack = (s == stall);
      chk("hi_en", pim_wr_en, 1);
      chk("hi_slice", pim_wr_slice, 0);
      chk("hi_addr", pim_wr_addr, 80'(addr));
      chk("hi_row", pim_wr_row, hr);
      chk("hi_ready", w_ready, 0);
      step();
    end
    pim_wr_ack = 1'b1;
    chk("lo_en", pim_wr_en, 1);
    chk("lo_slice", pim_wr_slice, 1);
    chk("lo_addr", pim_wr_addr, 80'(addr));
    chk("lo_row", pim_wr_row, lr);
    step();
  endtask

  task automatic chk_end();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_en", pim_wr_en, 0);
    chk("end_ready", w_ready, 0);
  endtask

  task automatic chk_reset();
    chk("rst_ready", w_ready, 0);
    chk("rst_en", pim_wr_en, 0);
    chk("rst_slice", pim_wr_slice, 0);
    chk("rst_addr", pim_wr_addr, 0);
    chk("rst_row", pim_wr_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_last, 0);
  endtask

  initial begin
    int w0;
    int d0;
    int b;
    int n;
    rst_n           = 1'b0;
    cfg_start       = 1'b0;
    cfg_base_addr   = '0;
    cfg_num_kernels = '0;
    w_valid         = 1'b0;
    w_data          = '0;
    w_last          = 1'b0;
    pim_wr_ack      = 1'b1;
    repeat (3) step();
    chk_reset();
    rst_n = 1'b1;
    step();

    // single kernel, w_k = k+7, base 3
    for (int k = 0; k < 25; k++) wk[k] = k + 7;
    start(3, 1);
    send(0, 25, -1);
    chk("t1_w0_hi", pim_wr_row[74:72], 0);
    check_write(3, 0);
    chk_end();
    chk("t1_err", err_last, 0);
    step();
    chk("t1_done_pulse", done, 0);

    // three kernels with address wrap
    w0 = wr_cnt;
    d0 = done_cnt;
    start(30, 3);
    for (int kk = 0; kk < 3; kk++) begin
      fill_random();
      send(0, 25, -1);
      check_write((30 + kk) % 32, 0);
      if (kk < 2) begin
        chk("t2_next_ready", w_ready, 1);
        chk("t2_next_busy", busy, 1);
      end
    end
    chk_end();
    step();
    chk("t2_writes", wr_cnt - w0, 6);
    chk("t2_dones", done_cnt - d0, 1);

    // ack stall in WR_HI
    fill_random();
    start(7, 1);
    send(0, 25, -1);
    check_write(7, 4);
    chk_end();
    step();

    // w_last misplaced on beat 10
    fill_random();
    start(12, 1);
    send(0, 25, 10);
    chk("t4_err_set", err_last, 1);
    check_write(12, 0);
    chk_end();
    step();
    chk("t4_err_sticky", err_last, 1);
    fill_random();
    start(13, 1);
    chk("t4_err_clear", err_last, 0);
    send(0, 25, -1);
    check_write(13, 0);
    chk_end();
    chk("t4_err_clean", err_last, 0);
    step();

    // zero-kernel session
    w0 = wr_cnt;
    start(5, 0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ready", w_ready, 0);
    step();
    chk("t5_done_pulse", done, 0);
    chk("t5_no_write", wr_cnt - w0, 0);

    // cfg_start while busy is ignored
    fill_random();
    start(20, 1);
    send(0, 10, -1);
    cfg_start       = 1'b1;
    cfg_base_addr   = 5'd2;
    cfg_num_kernels = 6'd9;
    step();
    cfg_start = 1'b0;
    send(10, 25, -1);
    check_write(20, 0);
    chk_end();
    step();

    // reset mid-kernel
    fill_random();
    start(9, 1);
    send(0, 12, -1);
    rst_n = 1'b0;
    step();
    chk_reset();
    rst_n = 1'b1;
    step();
    chk("t6_no_done", done, 0);
    fill_random();
    start(4, 1);
    send(0, 25, -1);
    check_write(4, 0);
    chk_end();
    step();

    // random sessions
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(0, 31));
      n = int'($urandom_range(1, 3));
      start(b, n);
      for (int kk = 0; kk < n; kk++) begin
        fill_random();
        send(0, 25, -1);
        check_write((b + kk) % 32, int'($urandom_range(0, 2)));
      end
      chk_end();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
